// File: rtl/pbit_pkg.sv
// Shared types and constants for the P-bit clamp sequencer and its ones-counter.
package pbit_pkg;

    localparam int N_OUT_PBITS = 8;
    localparam int TOTAL_PBITS = 53;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        REPORT,
        RELEASE
    } seq_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pbit_ones_counter.sv
// Bank of per-P-bit ones counters; cleared at pattern start, incremented on sampled sweeps.
module pbit_ones_counter
    import pbit_pkg::*;
#(
    parameter int N_OBS = 8,
    parameter int CNT_W = 9
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          en,
    input  logic [0:N_OBS-1]              bits,
    output logic [0:N_OBS-1][CNT_W-1:0]   res_cnt
);

    logic [0:N_OBS-1][CNT_W-1:0] cnt_q;
    logic [0:N_OBS-1][CNT_W-1:0] cnt_d;

    // Counter width covers SAMPLE_SWEEPS, so the sum can never wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            for (int i = 0; i < N_OBS; i++) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(bits[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign res_cnt = cnt_q;

endmodule

// File: rtl/clamp_sequencer.sv
// Applies one clamp pattern at a time, settles, counts observed P-bit ones, reports counts to the host.
// Optional feature macro CLAMP_SEQ_RELEASE_EN adds an unclamped RELEASE phase after each report.
module clamp_sequencer
    import pbit_pkg::*;
#(
    parameter int N_CLAMP        = N_OUT_PBITS,
    parameter int N_OBS          = 8,
    parameter int SETTLE_SWEEPS  = 16,
    parameter int SAMPLE_SWEEPS  = 256,
    parameter int RELEASE_SWEEPS = 4,
    parameter int CNT_W          = $clog2(SAMPLE_SWEEPS + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pat_valid,
    output logic                          pat_ready,
    input  logic [0:N_CLAMP-1]            pat_data,
    input  logic                          abort,
    input  logic                          sweep_tick,
    input  logic [0:N_OBS-1]              obs_pbit,
    output logic [0:N_CLAMP-1]            clamp,
    output logic                          clamp_EN,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [0:N_OBS-1][CNT_W-1:0]   res_cnt,
    output logic                          busy
);

    localparam int SWP_MAX = max3(SETTLE_SWEEPS, SAMPLE_SWEEPS, RELEASE_SWEEPS);
    localparam int SWP_W   = $clog2(SWP_MAX + 1);

    localparam logic [SWP_W-1:0] SETTLE_LAST =
        SWP_W'((SETTLE_SWEEPS > 0) ? SETTLE_SWEEPS - 1 : 0);
    localparam logic [SWP_W-1:0] SAMPLE_LAST =
        SWP_W'((SAMPLE_SWEEPS > 0) ? SAMPLE_SWEEPS - 1 : 0);
`ifdef CLAMP_SEQ_RELEASE_EN
    localparam logic [SWP_W-1:0] RELEASE_LAST =
        SWP_W'((RELEASE_SWEEPS > 0) ? RELEASE_SWEEPS - 1 : 0);
`endif

    seq_state_t         state_q, state_d;
    logic [SWP_W-1:0]   swp_q, swp_d;
    logic [0:N_CLAMP-1] clamp_q, clamp_d;
    logic               clamp_en_q, clamp_en_d;
    logic               res_valid_q, res_valid_d;
    logic               cnt_clr;
    logic               cnt_en;

    // Abort overrides everything else once a pattern is in flight; counts are left as they were.
    always_comb begin
        state_d     = state_q;
        swp_d       = swp_q;
        clamp_d     = clamp_q;
        clamp_en_d  = clamp_en_q;
        res_valid_d = res_valid_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;

        if (abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            clamp_en_d  = 1'b0;
            res_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pat_valid) begin
                        clamp_d    = pat_data;
                        clamp_en_d = 1'b1;
                        swp_d      = '0;
                        cnt_clr    = 1'b1;
                        state_d    = (SETTLE_SWEEPS == 0) ? SAMPLE : SETTLE;
                    end
                end
                SETTLE: begin
                    if (sweep_tick) begin
                        if (swp_q == SETTLE_LAST) begin
                            swp_d   = '0;
                            state_d = SAMPLE;
                        end else begin
                            swp_d = swp_q + SWP_W'(1);
                        end
                    end
                end
                SAMPLE: begin
                    if (sweep_tick) begin
                        cnt_en = 1'b1;
                        if (swp_q == SAMPLE_LAST) begin
                            swp_d       = '0;
                            res_valid_d = 1'b1;
                            state_d     = REPORT;
                        end else begin
                            swp_d = swp_q + SWP_W'(1);
                        end
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        res_valid_d = 1'b0;
                        clamp_en_d  = 1'b0;
                        swp_d       = '0;
`ifdef CLAMP_SEQ_RELEASE_EN
                        state_d     = (RELEASE_SWEEPS == 0) ? IDLE : RELEASE;
`else
                        state_d     = IDLE;
`endif
                    end
                end
                RELEASE: begin
`ifdef CLAMP_SEQ_RELEASE_EN
                    if (sweep_tick) begin
                        if (swp_q == RELEASE_LAST) begin
                            swp_d   = '0;
                            state_d = IDLE;
                        end else begin
                            swp_d = swp_q + SWP_W'(1);
                        end
                    end
`else
                    state_d = IDLE;
`endif
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            swp_q       <= '0;
            clamp_q     <= '0;
            clamp_en_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            swp_q       <= swp_d;
            clamp_q     <= clamp_d;
            clamp_en_q  <= clamp_en_d;
            res_valid_q <= res_valid_d;
        end
    end

    pbit_ones_counter #(
        .N_OBS (N_OBS),
        .CNT_W (CNT_W)
    ) u_ones_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .bits    (obs_pbit),
        .res_cnt (res_cnt)
    );

    assign pat_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign clamp     = clamp_q;
    assign clamp_EN  = clamp_en_q;
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_clamp_sequencer.sv
// Scoreboard bench for clamp_sequencer: default instance plus a SETTLE=0/SAMPLE=1 instance.
module tb_clamp_sequencer;

    typedef logic [0:7][15:0] cntvec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            pat_valid, pat_ready, abort, sweep_tick, res_valid, res_ready, clamp_EN, busy;
    logic [0:7]      pat_data, obs_pbit, clamp;
    logic [0:7][8:0] res_cnt;

    logic            s_pat_valid, s_pat_ready, s_abort, s_sweep_tick, s_res_valid, s_res_ready;
    logic            s_clamp_EN, s_busy;
    logic [0:7]      s_pat_data, s_obs_pbit, s_clamp;
    logic [0:7][0:0] s_res_cnt;

    cntvec_t q_main[$];
    cntvec_t q_s[$];
    int n_chk  = 0;
    int n_fail = 0;

    clamp_sequencer dut (
        .clk(clk), .rst_n(rst_n), .pat_valid(pat_valid), .pat_ready(pat_ready),
        .pat_data(pat_data), .abort(abort), .sweep_tick(sweep_tick), .obs_pbit(obs_pbit),
        .clamp(clamp), .clamp_EN(clamp_EN), .res_valid(res_valid), .res_ready(res_ready),
        .res_cnt(res_cnt), .busy(busy)
    );

    clamp_sequencer #(
        .SETTLE_SWEEPS(0), .SAMPLE_SWEEPS(1), .RELEASE_SWEEPS(0)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .pat_valid(s_pat_valid), .pat_ready(s_pat_ready),
        .pat_data(s_pat_data), .abort(s_abort), .sweep_tick(s_sweep_tick), .obs_pbit(s_obs_pbit),
        .clamp(s_clamp), .clamp_EN(s_clamp_EN), .res_valid(s_res_valid), .res_ready(s_res_ready),
        .res_cnt(s_res_cnt), .busy(s_busy)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitors: a rising res_valid pops the next expected vector; counts are compared every cycle it stays high.
    logic    prev_m = 1'b0;
    bit      have_m = 1'b0;
    cntvec_t cur_m;
    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            if (!prev_m) begin
                if (q_main.size() == 0) begin
                    chk("main_unexpected_res_valid_queue", q_main.size(), 1);
                    have_m = 1'b0;
                end else begin
                    cur_m  = q_main.pop_front();
                    have_m = 1'b1;
                end
            end
            if (have_m)
                for (int i = 0; i < 8; i++)
                    chk($sformatf("main_res_cnt[%0d]", i), int'(res_cnt[i]), int'(cur_m[i]));
        end
        prev_m = res_valid;
    end

    logic    prev_s = 1'b0;
    bit      have_s = 1'b0;
    cntvec_t cur_s;
    always @(negedge clk) begin
        if (rst_n && s_res_valid) begin
            if (!prev_s) begin
                if (q_s.size() == 0) begin
                    chk("s_unexpected_res_valid_queue", q_s.size(), 1);
                    have_s = 1'b0;
                end else begin
                    cur_s  = q_s.pop_front();
                    have_s = 1'b1;
                end
            end
            if (have_s)
                for (int i = 0; i < 8; i++)
                    chk($sformatf("s_res_cnt[%0d]", i), int'(s_res_cnt[i]), int'(cur_s[i]));
        end
        prev_s = s_res_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic [0:7] o);
        sweep_tick = 1'b1;
        obs_pbit   = o;
        step();
        sweep_tick = 1'b0;
        obs_pbit   = '0;
    endtask

    task automatic run_ticks(input int n, input logic [0:7] o);
        for (int k = 0; k < n; k++) begin
            tick(o);
            step();
        end
    endtask

    task automatic send(input logic [0:7] p);
        chk("pat_ready_idle", int'(pat_ready), 1);
        pat_valid = 1'b1;
        pat_data  = p;
        step();
        pat_valid = 1'b0;
        chk("clamp_EN_after_accept", int'(clamp_EN), 1);
        chk("clamp_after_accept", int'(clamp), int'(p));
        chk("busy_after_accept", int'(busy), 1);
    endtask

    task automatic finish_report();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("res_valid_after_handshake", int'(res_valid), 0);
        chk("clamp_EN_after_handshake", int'(clamp_EN), 0);
`ifdef CLAMP_SEQ_RELEASE_EN
        chk("busy_in_release", int'(busy), 1);
        chk("pat_ready_in_release", int'(pat_ready), 0);
        run_ticks(3, 8'hFF);
        chk("pat_ready_before_last_release", int'(pat_ready), 0);
        chk("clamp_EN_in_release", int'(clamp_EN), 0);
        tick(8'hFF);
        chk("pat_ready_after_release", int'(pat_ready), 1);
`else
        chk("pat_ready_after_handshake", int'(pat_ready), 1);
`endif
        step();
    endtask

    cntvec_t e;

    initial begin
        rst_n = 1'b0;
        pat_valid = 1'b0; pat_data = '0; abort = 1'b0; sweep_tick = 1'b0; obs_pbit = '0; res_ready = 1'b0;
        s_pat_valid = 1'b0; s_pat_data = '0; s_abort = 1'b0; s_sweep_tick = 1'b0; s_obs_pbit = '0;
        s_res_ready = 1'b0;
        repeat (3) step();
        chk("rst_clamp", int'(clamp), 0);
        chk("rst_clamp_EN", int'(clamp_EN), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pat_ready", int'(pat_ready), 1);
        chk("rst_res_cnt0", int'(res_cnt[0]), 0);
        rst_n = 1'b1;
        step();

        // 1: all ones, every count reaches SAMPLE_SWEEPS; settle ticks excluded.
        for (int i = 0; i < 8; i++) e[i] = 16'd256;
        q_main.push_back(e);
        send(8'hA5);
        run_ticks(16, 8'hFF);
        run_ticks(255, 8'hFF);
        chk("t1_res_valid_before_last", int'(res_valid), 0);
        tick(8'hFF);
        chk("t1_res_valid_after_last", int'(res_valid), 1);
        step();
        finish_report();

        // 2: bit0 toggles during sampling; settle ticks drive all ones.
        e = '0; e[0] = 16'd128;
        q_main.push_back(e);
        send(8'h3C);
        run_ticks(16, 8'hFF);
        for (int k = 0; k < 256; k++) begin
            tick((k % 2 == 0) ? 8'h80 : 8'h00);
            step();
        end
        chk("t2_res_valid", int'(res_valid), 1);
        finish_report();

        // 3: SETTLE=0, SAMPLE=1 instance.
        e = '0; e[0] = 16'd1; e[1] = 16'd1;
        q_s.push_back(e);
        s_pat_valid = 1'b1; s_pat_data = 8'h81;
        step();
        s_pat_valid = 1'b0;
        chk("t3_clamp_EN", int'(s_clamp_EN), 1);
        chk("t3_clamp", int'(s_clamp), 8'h81);
        chk("t3_res_valid_before_tick", int'(s_res_valid), 0);
        s_sweep_tick = 1'b1; s_obs_pbit = 8'hC0;
        step();
        s_sweep_tick = 1'b0; s_obs_pbit = '0;
        chk("t3_res_valid_after_tick", int'(s_res_valid), 1);
        step();
        s_res_ready = 1'b1;
        step();
        s_res_ready = 1'b0;
        chk("t3_res_valid_after_hs", int'(s_res_valid), 0);
        chk("t3_pat_ready_after_hs", int'(s_pat_ready), 1);
        chk("t3_clamp_EN_after_hs", int'(s_clamp_EN), 0);

        // 4: host stalls the report while ticks and a new pattern keep arriving.
        e = '0; e[3] = 16'd100; e[7] = 16'd256;
        q_main.push_back(e);
        send(8'h0F);
        run_ticks(16, 8'h00);
        for (int k = 0; k < 256; k++) begin
            tick(8'h01 | ((k < 100) ? 8'h10 : 8'h00));
            step();
        end
        for (int c = 0; c < 50; c++) begin
            sweep_tick = (c % 2 == 0);
            obs_pbit   = 8'hFF;
            pat_valid  = 1'b1;
            pat_data   = 8'h11;
            step();
            chk("t4_clamp_EN_hold", int'(clamp_EN), 1);
            chk("t4_pat_ready_hold", int'(pat_ready), 0);
            chk("t4_clamp_hold", int'(clamp), 8'h0F);
        end
        sweep_tick = 1'b0; obs_pbit = '0; pat_valid = 1'b0;
        finish_report();

        // 5: abort on sample tick 100, then abort-in-IDLE with a same-cycle pattern.
        send(8'hFF);
        run_ticks(16, 8'hFF);
        run_ticks(99, 8'hFF);
        abort = 1'b1; sweep_tick = 1'b1; obs_pbit = 8'hFF;
        step();
        abort = 1'b0; sweep_tick = 1'b0; obs_pbit = '0;
        chk("t5_busy_after_abort", int'(busy), 0);
        chk("t5_clamp_EN_after_abort", int'(clamp_EN), 0);
        chk("t5_res_valid_after_abort", int'(res_valid), 0);
        chk("t5_pat_ready_after_abort", int'(pat_ready), 1);
        chk("t5_res_cnt0_kept", int'(res_cnt[0]), 99);
        chk("t5_res_cnt5_kept", int'(res_cnt[5]), 99);
        e = '0; e[1] = 16'd256; e[3] = 16'd256; e[4] = 16'd256; e[6] = 16'd256;
        q_main.push_back(e);
        abort = 1'b1; pat_valid = 1'b1; pat_data = 8'h5A;
        step();
        abort = 1'b0; pat_valid = 1'b0;
        chk("t5_clamp_EN_abort_idle", int'(clamp_EN), 1);
        chk("t5_clamp_abort_idle", int'(clamp), 8'h5A);
        run_ticks(16, 8'h00);
        run_ticks(256, 8'h5A);
        chk("t5_res_valid", int'(res_valid), 1);
        finish_report();

        // 6: reset mid-sample.
        send(8'hC3);
        run_ticks(16, 8'hFF);
        run_ticks(10, 8'hFF);
        rst_n = 1'b0;
        step();
        chk("t6_clamp", int'(clamp), 0);
        chk("t6_clamp_EN", int'(clamp_EN), 0);
        chk("t6_res_valid", int'(res_valid), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_res_cnt0", int'(res_cnt[0]), 0);
        rst_n = 1'b1;
        step();
        step();

        chk("main_reports_outstanding", q_main.size(), 0);
        chk("s_reports_outstanding", q_s.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
